// File: rtl/fb_arbiter.sv
// Frame-buffer arbiter: shares one single-port frame memory between HDMI
// scan-out reads (2x replicated 320x240 image) and camera writes via a FIFO.
module fb_arbiter #(
    parameter int ADDR_W     = 17,
    parameter int DATA_W     = 12,
    parameter int FIFO_DEPTH = 8
) (
    input  logic              clk25,
    input  logic              rst_n,
    input  logic              en,
    input  logic [9:0]        vid_x,
    input  logic [9:0]        vid_y,
    input  logic              cam_valid,
    input  logic [ADDR_W-1:0] cam_addr,
    input  logic [DATA_W-1:0] cam_data,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [7:0]        red,
    output logic [7:0]        green,
    output logic [7:0]        blue,
    output logic              fifo_full,
    output logic              ovf
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam logic [0:0] SYNC = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    logic [0:0]        state;
    logic [ADDR_W-1:0] fa [FIFO_DEPTH];
    logic [DATA_W-1:0] fd [FIFO_DEPTH];
    logic [PW-1:0]     wptr;
    logic [PW-1:0]     rptr;
    logic [PW:0]       count;
    logic              win;
    logic              pop;
    logic              push;
    logic              drop;
    logic              v1;
    logic              v2;
    logic [8:0]        rx;
    logic [8:0]        ry;
    logic [ADDR_W-1:0] rd_addr;

    assign rx = vid_x[9:1];
    assign ry = vid_y[9:1];
    // y*320 as (y<<8)+(y<<6)
    assign rd_addr = ADDR_W'({ry, 8'b0}) + ADDR_W'({ry, 6'b0}) + ADDR_W'(rx);

    assign win = (state == RUN) && en && (vid_x < 10'd640) && (vid_y < 10'd480);
    assign fifo_full = (count == (PW+1)'(FIFO_DEPTH));
    assign pop  = !win && (count != '0);
    assign push = cam_valid && (!fifo_full || pop);
    assign drop = cam_valid && fifo_full && !pop;

    always_ff @(posedge clk25) begin
        if (!rst_n) begin
            state <= SYNC;
        end else begin
            case (state)
                SYNC: if (en && vid_x == '0 && vid_y == '0) state <= RUN;
                RUN:  if (!en) state <= SYNC;
                default: state <= SYNC;
            endcase
        end
    end

    always_ff @(posedge clk25) begin
        if (push) begin
            fa[wptr] <= cam_addr;
            fd[wptr] <= cam_data;
        end
    end

    always_ff @(posedge clk25) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
            ovf   <= 1'b0;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (pop) rptr <= rptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (drop) ovf <= 1'b1;
        end
    end

    // Reads own the port; writes only fill cycles outside the window.
    always_ff @(posedge clk25) begin
        if (!rst_n) begin
            mem_addr  <= '0;
            mem_we    <= 1'b0;
            mem_wdata <= '0;
        end else if (win) begin
            mem_addr <= rd_addr;
            mem_we   <= 1'b0;
        end else if (pop) begin
            mem_addr  <= fa[rptr];
            mem_wdata <= fd[rptr];
            mem_we    <= 1'b1;
        end else begin
            mem_we <= 1'b0;
        end
    end

    always_ff @(posedge clk25) begin
        if (!rst_n) begin
            v1    <= 1'b0;
            v2    <= 1'b0;
            red   <= '0;
            green <= '0;
            blue  <= '0;
        end else begin
            v1 <= win;
            v2 <= v1;
            if (v2) begin
                red   <= {mem_rdata[11:8], mem_rdata[11:8]};
                green <= {mem_rdata[7:4], mem_rdata[7:4]};
                blue  <= {mem_rdata[3:0], mem_rdata[3:0]};
            end else begin
                red   <= '0;
                green <= '0;
                blue  <= '0;
            end
        end
    end
endmodule

// File: tb/tb_fb_arbiter.sv
// Bench for fb_arbiter: directed scenarios plus randomized traffic against
// a queue-based behavioural model of the arbiter and frame memory.
module tb_fb_arbiter;
    localparam int AW = 17;
    localparam int DW = 12;
    localparam int DEPTH = 8;

    logic          clk25 = 1'b0;
    logic          rst_n;
    logic          en;
    logic [9:0]    vid_x;
    logic [9:0]    vid_y;
    logic          cam_valid;
    logic [AW-1:0] cam_addr;
    logic [DW-1:0] cam_data;
    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic [7:0]    red;
    logic [7:0]    green;
    logic [7:0]    blue;
    logic          fifo_full;
    logic          ovf;
    int checks = 0;
    int errors = 0;

    always #5 clk25 = ~clk25;

    fb_arbiter #(.ADDR_W(AW), .DATA_W(DW), .FIFO_DEPTH(DEPTH)) dut (
        .clk25(clk25), .rst_n(rst_n), .en(en),
        .vid_x(vid_x), .vid_y(vid_y),
        .cam_valid(cam_valid), .cam_addr(cam_addr), .cam_data(cam_data),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .red(red), .green(green), .blue(blue),
        .fifo_full(fifo_full), .ovf(ovf)
    );

    function automatic logic [DW-1:0] init_val(int a);
        return DW'(a * 37 + 5 + (a >> 9));
    endfunction

    // Single-port synchronous frame memory, read data one cycle after address
    logic [DW-1:0] ram [1 << AW];
    initial begin
        logic [DW-1:0] rd;
        for (int i = 0; i < (1 << AW); i++) ram[i] = init_val(i);
        mem_rdata <= '0;
        forever begin
            @(posedge clk25);
            rd = ram[mem_addr];
            if (mem_we) ram[mem_addr] = mem_wdata;
            mem_rdata <= rd;
        end
    end

    // Behavioural model
    typedef struct packed {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } ent_t;
    ent_t          mq[$];
    logic [DW-1:0] mwr[int];
    logic [23:0]   rgb_q[$];
    bit            m_run;
    logic          m_ovf;
    logic [AW-1:0] exp_addr;
    logic          exp_we;
    logic [DW-1:0] exp_wdata;
    logic          exp_full;
    logic [23:0]   exp_rgb;

    function automatic logic [DW-1:0] mem_read(int a);
        return mwr.exists(a) ? mwr[a] : init_val(a);
    endfunction

    function automatic logic [23:0] expand(logic [DW-1:0] c);
        return {c[11:8], c[11:8], c[7:4], c[7:4], c[3:0], c[3:0]};
    endfunction

    task automatic cycle();
        logic [23:0] pix;
        bit          w;
        bit          p;
        ent_t        e;
        int          ad;
        pix = '0;
        if (!rst_n) begin
            m_run = 0;
            mq.delete();
            m_ovf = 1'b0;
            exp_addr = '0;
            exp_we = 1'b0;
            exp_wdata = '0;
            exp_full = 1'b0;
            rgb_q.delete();
            rgb_q.push_back('0);
            rgb_q.push_back('0);
            exp_rgb = '0;
        end else begin
            w = m_run && en && vid_x < 640 && vid_y < 480;
            p = !w && mq.size() > 0;
            if (w) begin
                ad = (int'(vid_y) / 2) * 320 + int'(vid_x) / 2;
                exp_addr = AW'(ad);
                exp_we = 1'b0;
                pix = expand(mem_read(ad));
            end else if (p) begin
                e = mq.pop_front();
                exp_addr = e.a;
                exp_wdata = e.d;
                exp_we = 1'b1;
                mwr[int'(e.a)] = e.d;
            end else begin
                exp_we = 1'b0;
            end
            if (cam_valid) begin
                if (mq.size() < DEPTH) begin
                    e.a = cam_addr;
                    e.d = cam_data;
                    mq.push_back(e);
                end else begin
                    m_ovf = 1'b1;
                end
            end
            exp_full = (mq.size() == DEPTH);
            if (m_run && !en) m_run = 0;
            else if (!m_run && en && vid_x == 0 && vid_y == 0) m_run = 1;
            rgb_q.push_back(pix);
            exp_rgb = rgb_q.pop_front();
        end
        @(posedge clk25);
        #1;
    endtask

    task automatic set_vid(int x, int y);
        vid_x = 10'(x);
        vid_y = 10'(y);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        cam_valid = 1'b0;
        cycle();
        rst_n = 1'b1;
    endtask

    task automatic enter_run();
        en = 1'b1;
        set_vid(0, 0);
        cycle();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        en = 1'b0;
        cam_valid = 1'b0;
        cam_addr = '0;
        cam_data = '0;
        set_vid(700, 500);
        cycle();
        cycle();
        rst_n = 1'b1;
        checks++;
        if ({mem_we, mem_addr, mem_wdata} !== '0) begin
            errors++;
            $display("FAIL reset_mem: got we=%b addr=%0d wdata=%h expected 0", mem_we, mem_addr, mem_wdata);
        end
        checks++;
        if ({red, green, blue} !== 24'h0) begin
            errors++;
            $display("FAIL reset_rgb: got %h expected 000000", {red, green, blue});
        end
        checks++;
        if ({fifo_full, ovf} !== 2'b00) begin
            errors++;
            $display("FAIL reset_flags: got full=%b ovf=%b expected 0 0", fifo_full, ovf);
        end
    endtask

    task automatic test_read_timing();
        en = 1'b1;
        set_vid(700, 500);
        cam_valid = 1'b1;
        cam_addr = '0;
        cam_data = 12'h0F0;
        cycle();
        cam_valid = 1'b0;
        cycle();
        checks++;
        if (mem_we !== 1'b1 || mem_addr !== '0 || mem_wdata !== 12'h0F0) begin
            errors++;
            $display("FAIL preload_write: got we=%b addr=%0d data=%h expected 1 0 0f0", mem_we, mem_addr, mem_wdata);
        end
        enter_run();
        set_vid(0, 0);
        cycle();
        checks++;
        if (mem_addr !== '0 || mem_we !== 1'b0) begin
            errors++;
            $display("FAIL read_addr00: got addr=%0d we=%b expected 0 0", mem_addr, mem_we);
        end
        set_vid(2, 0);
        cycle();
        set_vid(4, 0);
        cycle();
        checks++;
        if ({red, green, blue} !== 24'h00FF00) begin
            errors++;
            $display("FAIL read_rgb00: got %h expected 00ff00", {red, green, blue});
        end
    endtask

    task automatic test_addr_map();
        set_vid(639, 479);
        cycle();
        checks++;
        if (mem_addr !== 17'd76799) begin
            errors++;
            $display("FAIL addr_639_479: got %0d expected 76799", mem_addr);
        end
        set_vid(2, 3);
        cycle();
        checks++;
        if (mem_addr !== 17'd321) begin
            errors++;
            $display("FAIL addr_2_3: got %0d expected 321", mem_addr);
        end
    endtask

    task automatic test_drain();
        logic [DW-1:0] dat [3];
        bit            w;
        for (int k = 0; k < 3; k++) dat[k] = DW'($urandom);
        for (int x = 100; x <= 650; x++) begin
            set_vid(x, 10);
            cam_valid = (x >= 100 && x <= 102);
            cam_addr = AW'(10 + x - 100);
            cam_data = (x >= 100 && x <= 102) ? dat[x - 100] : '0;
            cycle();
            w = (x >= 640 && x <= 642);
            checks++;
            if (mem_we !== w) begin
                errors++;
                $display("FAIL drain_we x=%0d: got %b expected %b", x, mem_we, w);
            end
            if (w) begin
                checks++;
                if (mem_addr !== AW'(10 + x - 640) || mem_wdata !== dat[x - 640]) begin
                    errors++;
                    $display("FAIL drain_entry x=%0d: got addr=%0d data=%h expected %0d %h",
                             x, mem_addr, mem_wdata, 10 + x - 640, dat[x - 640]);
                end
            end
        end
        cam_valid = 1'b0;
    endtask

    task automatic test_overflow();
        do_reset();
        enter_run();
        for (int i = 0; i < 9; i++) begin
            set_vid(50 + i, 20);
            cam_valid = 1'b1;
            cam_addr = AW'(100 + i);
            cam_data = DW'(i + 1);
            cycle();
            checks++;
            if (fifo_full !== (i >= 7) || ovf !== (i == 8) || mem_we !== 1'b0) begin
                errors++;
                $display("FAIL ovf_fill i=%0d: got full=%b ovf=%b we=%b expected %b %b 0",
                         i, fifo_full, ovf, mem_we, i >= 7, i == 8);
            end
        end
        cam_valid = 1'b0;
        set_vid(700, 20);
        for (int k = 0; k < 8; k++) begin
            cycle();
            checks++;
            if (mem_we !== 1'b1 || mem_addr !== AW'(100 + k) || ovf !== 1'b1) begin
                errors++;
                $display("FAIL ovf_drain k=%0d: got we=%b addr=%0d ovf=%b expected 1 %0d 1",
                         k, mem_we, mem_addr, ovf, 100 + k);
            end
        end
        cycle();
        checks++;
        if (mem_we !== 1'b0 || ovf !== 1'b1 || fifo_full !== 1'b0) begin
            errors++;
            $display("FAIL ovf_dropped: got we=%b ovf=%b full=%b expected 0 1 0", mem_we, ovf, fifo_full);
        end
        do_reset();
        checks++;
        if (ovf !== 1'b0) begin
            errors++;
            $display("FAIL ovf_clear: got %b expected 0", ovf);
        end
    endtask

    task automatic test_push_pop();
        do_reset();
        enter_run();
        for (int i = 0; i < 8; i++) begin
            set_vid(50 + i, 20);
            cam_valid = 1'b1;
            cam_addr = AW'(100 + i);
            cam_data = DW'(i);
            cycle();
        end
        set_vid(700, 20);
        cam_addr = AW'(200);
        cam_data = 12'hABC;
        cycle();
        cam_valid = 1'b0;
        checks++;
        if (fifo_full !== 1'b1 || ovf !== 1'b0 || mem_we !== 1'b1 || mem_addr !== AW'(100)) begin
            errors++;
            $display("FAIL pushpop: got full=%b ovf=%b we=%b addr=%0d expected 1 0 1 100",
                     fifo_full, ovf, mem_we, mem_addr);
        end
        for (int k = 0; k < 8; k++) begin
            cycle();
            checks++;
            if (mem_we !== 1'b1 || mem_addr !== AW'(k < 7 ? 101 + k : 200)) begin
                errors++;
                $display("FAIL pushpop_drain k=%0d: got we=%b addr=%0d expected 1 %0d",
                         k, mem_we, mem_addr, k < 7 ? 101 + k : 200);
            end
        end
    endtask

    task automatic test_enable();
        logic [23:0] c_pix;
        logic [23:0] r_pix;
        c_pix = expand(mem_read(15 * 320 + 6));
        r_pix = expand(mem_read(15 * 320 + 10));
        en = 1'b1;
        for (int i = 0; i < 7; i++) begin
            set_vid(10 + i, 30);
            en = (i < 3);
            cycle();
            if (i == 4) begin
                checks++;
                if ({red, green, blue} !== c_pix) begin
                    errors++;
                    $display("FAIL en_inflight: got %h expected %h", {red, green, blue}, c_pix);
                end
            end
            if (i >= 5) begin
                checks++;
                if ({red, green, blue} !== 24'h0) begin
                    errors++;
                    $display("FAIL en_black i=%0d: got %h expected 000000", i, {red, green, blue});
                end
            end
        end
        en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            set_vid(5 + i, 5);
            cycle();
        end
        checks++;
        if ({red, green, blue} !== 24'h0 || mem_we !== 1'b0) begin
            errors++;
            $display("FAIL en_sync_wait: got rgb=%h we=%b expected 000000 0", {red, green, blue}, mem_we);
        end
        enter_run();
        set_vid(20, 30);
        cycle();
        set_vid(21, 30);
        cycle();
        cycle();
        checks++;
        if ({red, green, blue} !== r_pix) begin
            errors++;
            $display("FAIL en_resume: got %h expected %h", {red, green, blue}, r_pix);
        end
    endtask

    task automatic test_reset_queue();
        for (int i = 0; i < 5; i++) begin
            set_vid(50 + i, 20);
            cam_valid = 1'b1;
            cam_addr = AW'(300 + i);
            cam_data = DW'($urandom);
            cycle();
        end
        set_vid(700, 20);
        do_reset();
        for (int k = 0; k < 4; k++) begin
            cycle();
            checks++;
            if (mem_we !== 1'b0 || fifo_full !== 1'b0) begin
                errors++;
                $display("FAIL rstq_k%0d: got we=%b full=%b expected 0 0", k, mem_we, fifo_full);
            end
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 4000; n++) begin
            rst_n = ($urandom % 300) != 0;
            en = ($urandom % 25) != 0;
            if ($urandom % 12 == 0) set_vid(0, 0);
            else set_vid($urandom_range(0, 799), $urandom_range(0, 524));
            cam_valid = ($urandom % 3) != 0;
            cam_addr = AW'($urandom_range(0, 76799));
            cam_data = DW'($urandom);
            cycle();
            checks++;
            if (mem_we !== exp_we || mem_addr !== exp_addr || mem_wdata !== exp_wdata) begin
                errors++;
                $display("FAIL rnd_mem n=%0d: got we=%b addr=%0d data=%h expected %b %0d %h",
                         n, mem_we, mem_addr, mem_wdata, exp_we, exp_addr, exp_wdata);
            end
            checks++;
            if ({red, green, blue} !== exp_rgb) begin
                errors++;
                $display("FAIL rnd_rgb n=%0d: got %h expected %h", n, {red, green, blue}, exp_rgb);
            end
            checks++;
            if (fifo_full !== exp_full || ovf !== m_ovf) begin
                errors++;
                $display("FAIL rnd_flags n=%0d: got full=%b ovf=%b expected %b %b",
                         n, fifo_full, ovf, exp_full, m_ovf);
            end
        end
        rst_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_read_timing();
        test_addr_map();
        test_drain();
        test_overflow();
        test_push_pop();
        test_enable();
        test_reset_queue();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
